sbinit_seq: RTL

SBINIT_SEQ -- requirements
Module: sbinit_seq

---
 rtl/sbinit_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sbinit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sbinit_seq
//  Purpose  : Sideband initialisation sequencer. Drives the SB clock-pattern
//             generator until the partner pattern is seen, sends a short
//             pattern tail, then exchanges OUT_OF_RESET, DONE_REQ and
//             DONE_RESP messages with the link partner. Every wait is guarded
//             by a timeout that lands the sequencer in ERROR.
//  Ports    : clk_100MHz      - single clock, rising edge
//             reset           - asynchronous, active-high reset
//             start_i         - level request, sampled in IDLE
//             pattern_det_i   - one-cycle pulse, partner pattern detected
//             rx_msg_valid_i  - qualifies rx_msg_code_i for one cycle
//             rx_msg_code_i   - received SB message code
//             tx_msg_ack_i    - one-cycle acceptance of the presented message
//             pattern_en_o    - clock-pattern generator enable
//             tx_msg_valid_o  - transmit request
//             tx_msg_code_o   - message code to transmit
//             busy_o          - sequence in progress
//             done_o          - sequence completed
//             error_o         - sequence timed out
//             state_o         - current state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module sbinit_seq #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000,
  parameter int unsigned PATTERN_TAIL   = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start_i,
  input  logic       pattern_det_i,
  input  logic       rx_msg_valid_i,
  input  logic [7:0] rx_msg_code_i,
  input  logic       tx_msg_ack_i,
  output logic       pattern_en_o,
  output logic       tx_msg_valid_o,
  output logic [7:0] tx_msg_code_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [2:0] state_o
);

  localparam logic [7:0]  c_MSG_OOR      = 8'h01;
  localparam logic [7:0]  c_MSG_DREQ     = 8'h02;
  localparam logic [7:0]  c_MSG_DRSP     = 8'h03;
  localparam logic [19:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - 20'd1;
  localparam logic [7:0]  c_TAIL_LAST    = 8'(PATTERN_TAIL - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PATTERN = 3'd1,
    S_TAIL    = 3'd2,
    S_OOR     = 3'd3,
    S_DREQ    = 3'd4,
    S_DRSP    = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t      r_state;
  logic [19:0] r_timer;
  logic [7:0]  r_tail_cnt;
  logic        r_rx_oor;
  logic        r_rx_dreq;
  logic        r_rx_drsp;
  logic        r_acked;

  state_t      w_next;
  logic        w_changed;
  logic        w_timeout;
  logic        w_timed;
  logic        w_ack;
  logic        w_msg_done;
  logic        w_hit_oor;
  logic        w_hit_dreq;
  logic        w_hit_drsp;
  logic        w_start_seq;

  assign state_o = r_state;

  // Ack only counts while a request is actually pending.
  assign w_ack      = tx_msg_valid_o & tx_msg_ack_i;
  assign w_msg_done = r_acked | w_ack;

  assign w_hit_oor  = rx_msg_valid_i & (rx_msg_code_i == c_MSG_OOR);
  assign w_hit_dreq = rx_msg_valid_i & (rx_msg_code_i == c_MSG_DREQ);
  assign w_hit_drsp = rx_msg_valid_i & (rx_msg_code_i == c_MSG_DRSP);

  assign w_timed     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_timeout   = w_timed && (r_timer == c_TIMEOUT_LAST);
  assign w_start_seq = (r_state == S_IDLE) && start_i;
  assign w_changed   = (w_next != r_state);

  // Next-state decision. Timeout is checked first so it wins over any
  // advance condition arriving in the same cycle. A partner message arriving
  // in the same cycle as our ack is accepted alongside the sticky flag.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_next = S_PATTERN;
      S_PATTERN: begin
        if (w_timeout)          w_next = S_ERROR;
        else if (pattern_det_i) w_next = S_TAIL;
      end
      S_TAIL: begin
        if (w_timeout)                       w_next = S_ERROR;
        else if (r_tail_cnt == c_TAIL_LAST)  w_next = S_OOR;
      end
      S_OOR: begin
        if (w_timeout)                                   w_next = S_ERROR;
        else if (w_msg_done && (r_rx_oor | w_hit_oor))   w_next = S_DREQ;
      end
      S_DREQ: begin
        if (w_timeout)                                   w_next = S_ERROR;
        else if (w_msg_done && (r_rx_dreq | w_hit_dreq)) w_next = S_DRSP;
      end
      S_DRSP: begin
        if (w_timeout)                                   w_next = S_ERROR;
        else if (w_msg_done && (r_rx_drsp | w_hit_drsp)) w_next = S_DONE;
      end
      S_DONE:    if (!start_i) w_next = S_IDLE;
      S_ERROR:   if (!start_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State, counters, flags and all outputs. Outputs are loaded from the
  // next state so they change on the same edge as state_o.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_timer        <= 20'd0;
      r_tail_cnt     <= 8'd0;
      r_rx_oor       <= 1'b0;
      r_rx_dreq      <= 1'b0;
      r_rx_drsp      <= 1'b0;
      r_acked        <= 1'b0;
      pattern_en_o   <= 1'b0;
      tx_msg_valid_o <= 1'b0;
      tx_msg_code_o  <= 8'h00;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_changed || !w_timed) r_timer <= 20'd0;
      else                       r_timer <= r_timer + 20'd1;

      if (w_changed)               r_tail_cnt <= 8'd0;
      else if (r_state == S_TAIL)  r_tail_cnt <= r_tail_cnt + 8'd1;

      // Flags persist across states so partner messages that arrive early
      // are remembered; a message coinciding with the clear is dropped.
      if (w_start_seq) begin
        r_rx_oor  <= 1'b0;
        r_rx_dreq <= 1'b0;
        r_rx_drsp <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (w_hit_oor)  r_rx_oor  <= 1'b1;
        if (w_hit_dreq) r_rx_dreq <= 1'b1;
        if (w_hit_drsp) r_rx_drsp <= 1'b1;
      end

      // One message per state visit: raised on entry, dropped after ack.
      // Leaving for any other state (including ERROR) abandons the request.
      if (w_changed) begin
        r_acked <= 1'b0;
        case (w_next)
          S_OOR: begin
            tx_msg_valid_o <= 1'b1;
            tx_msg_code_o  <= c_MSG_OOR;
          end
          S_DREQ: begin
            tx_msg_valid_o <= 1'b1;
            tx_msg_code_o  <= c_MSG_DREQ;
          end
          S_DRSP: begin
            tx_msg_valid_o <= 1'b1;
            tx_msg_code_o  <= c_MSG_DRSP;
          end
          default: begin
            tx_msg_valid_o <= 1'b0;
            tx_msg_code_o  <= 8'h00;
          end
        endcase
      end else if (w_ack) begin
        r_acked        <= 1'b1;
        tx_msg_valid_o <= 1'b0;
        tx_msg_code_o  <= 8'h00;
      end

      pattern_en_o <= (w_next == S_PATTERN) || (w_next == S_TAIL);
      busy_o       <= (w_next != S_IDLE) && (w_next != S_DONE) && (w_next != S_ERROR);
      done_o       <= (w_next == S_DONE);
      error_o      <= (w_next == S_ERROR);
    end
  end

endmodule
`default_nettype wire
